// File: rtl/mux_info_scan.sv
// mux_info_scan: selects one of N_CH multi-digit BCD words for the display path,
// either manually (sel) or by round-robin scanning with a programmable dwell time.
// Optional leading-zero blanking; hold freezes output, channel and dwell counter.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   numero_in  channel c, digit d at [(c*N_DIG+d)*4 +: 4], d=0 least significant
//   sel        manual channel select (out-of-range values are ignored)
//   mode       0 = manual, 1 = auto scan
//   hold       freeze output, channel and dwell counter
//   s_mux      selected, optionally blanked digits (registered, 1 cycle latency)
//   ch_act     channel currently driving s_mux
//   upd        one-cycle pulse after ch_act takes a new value
module mux_info_scan #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned N_DIG    = 4,
    parameter int unsigned DWELL    = 50_000_000,
    parameter int unsigned BLANK_LZ = 1,
    parameter int unsigned SEL_W    = $clog2(N_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH*N_DIG*4-1:0]     numero_in,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        mode,
    input  logic                        hold,
    output logic [N_DIG*4-1:0]          s_mux,
    output logic [SEL_W-1:0]            ch_act,
    output logic                        upd
);

    localparam int unsigned WORD_W = N_DIG * 4;
    localparam int unsigned CNT_W  = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_V   = (SEL_W + 1)'(N_CH);

    typedef enum logic [1:0] {
        ST_MAN  = 2'd0,
        ST_SCAN = 2'd1,
        ST_FRZ  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SEL_W-1:0]    ch_nxt;
    logic [WORD_W-1:0]   word_sel;
    logic [WORD_W-1:0]   word_fmt;

    // Replace zero digits above the most significant non-zero digit with 4'hF;
    // digit 0 is always shown so that a zero value still displays "0".
    function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
        logic lead;
        fmt_word = w;
        lead     = (BLANK_LZ != 0);
        for (int d = int'(N_DIG) - 1; d >= 1; d--) begin
            if (lead && (w[d*4 +: 4] == 4'h0)) begin
                fmt_word[d*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction

    // Next state, dwell counter and channel; hold outranks everything, and a
    // mode change outranks a dwell expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch_act;
        if (hold) begin
            state_nxt = ST_FRZ;
        end else if (!mode) begin
            state_nxt = ST_MAN;
            cnt_nxt   = '0;
            if ({1'b0, sel} < N_CH_V) begin
                ch_nxt = sel;
            end
        end else begin
            state_nxt = ST_SCAN;
            if (state == ST_MAN) begin
                // entry from manual: restart dwell on the current channel
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                ch_nxt  = (ch_act == CH_LAST) ? '0 : SEL_W'(ch_act + 1'b1);
            end else begin
                // SCAN, or leaving FRZ: resume from the held count
                cnt_nxt = CNT_W'(cnt + 1'b1);
            end
        end
    end

    // Pick the word of the channel that will be active after this edge.
    always_comb begin
        word_sel = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (ch_nxt == SEL_W'(c)) begin
                word_sel = numero_in[c*WORD_W +: WORD_W];
            end
        end
        word_fmt = fmt_word(word_sel);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_MAN;
            cnt    <= '0;
            ch_act <= '0;
            s_mux  <= '0;
            upd    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ch_act <= ch_nxt;
            if (state_nxt != ST_FRZ) begin
                s_mux <= word_fmt;
                upd   <= (ch_nxt != ch_act);
            end else begin
                upd   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_info_scan.sv
// Self-checking bench for mux_info_scan: directed test-plan scenarios followed by
// randomized stimulus, all compared against a behavioural model of the block.
module tb_mux_info_scan;

    localparam int N_CH  = 3;
    localparam int N_DIG = 4;
    localparam int DWELL = 4;
    localparam int SEL_W = 2;

    localparam int MANUAL   = 0;
    localparam int SCANNING = 1;
    localparam int FROZEN   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [N_CH*N_DIG*4-1:0] numero_in;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic                    hold;
    logic [N_DIG*4-1:0]      s_mux;
    logic [SEL_W-1:0]        ch_act;
    logic                    upd;

    logic [15:0] ch_data [N_CH];

    int n_checks = 0;
    int n_err    = 0;

    // model state
    int          m_ch;
    int          m_cnt;
    int          m_last;
    logic [15:0] m_out;
    logic        m_upd;

    assign numero_in = {ch_data[2], ch_data[1], ch_data[0]};

    mux_info_scan #(
        .N_CH     (N_CH),
        .N_DIG    (N_DIG),
        .DWELL    (DWELL),
        .BLANK_LZ (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .numero_in (numero_in),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
        .s_mux     (s_mux),
        .ch_act    (ch_act),
        .upd       (upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Blanking by locating the most significant non-zero digit.
    function automatic logic [15:0] blank(input logic [15:0] w);
        int msd;
        msd = 0;
        for (int d = 0; d < N_DIG; d++) begin
            if (w[d*4 +: 4] != 4'h0) msd = d;
        end
        blank = w;
        for (int d = 1; d < N_DIG; d++) begin
            if (d > msd) blank[d*4 +: 4] = 4'hF;
        end
    endfunction

    task automatic model_reset();
        m_ch   = 0;
        m_cnt  = 0;
        m_last = MANUAL;
        m_out  = 16'h0000;
        m_upd  = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using the current inputs.
    task automatic model_edge();
        int nxt;
        if (hold) begin
            m_upd  = 1'b0;
            m_last = FROZEN;
            return;
        end
        nxt = m_ch;
        if (!mode) begin
            m_cnt = 0;
            if (int'(sel) < N_CH) nxt = int'(sel);
            m_last = MANUAL;
        end else begin
            if (m_last == MANUAL) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_cnt = 0;
                    nxt   = (m_ch + 1) % N_CH;
                end
            end
            m_last = SCANNING;
        end
        m_upd = (nxt != m_ch);
        m_ch  = nxt;
        m_out = blank(ch_data[nxt]);
    endtask

    // Advance one clock, update the model and compare all outputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("s_mux", 32'(s_mux), 32'(m_out));
        check("ch_act", 32'(ch_act), 32'(m_ch));
        check("upd", 32'(upd), 32'(m_upd));
    endtask

    // Step until ch_act changes (bounded); returns number of edges taken.
    task automatic wait_adv(output int n);
        logic [SEL_W-1:0] prev;
        prev = ch_act;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (ch_act != prev) break;
        end
    endtask

    // Async reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_s_mux", 32'(s_mux), 32'h0);
        check("rst_ch_act", 32'(ch_act), 32'h0);
        check("rst_upd", 32'(upd), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int d = 0; d < N_DIG; d++) begin
            w[d*4 +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
        end
        return w;
    endfunction

    initial begin
        int n;
        int prev;
        int tgt;
        logic [15:0] held;

        rst_n = 1'b0;
        mode  = 1'b0;
        hold  = 1'b0;
        sel   = 2'd0;
        ch_data[0] = 16'h2605;
        ch_data[1] = 16'h1046;
        ch_data[2] = 16'h0040;
        model_reset();
        #12;
        check("reset_s_mux", 32'(s_mux), 32'h0);
        check("reset_ch_act", 32'(ch_act), 32'h0);
        check("reset_upd", 32'(upd), 32'h0);
        rst_n = 1'b1;

        // manual select
        step();
        check("man_ch0", 32'(s_mux), 32'h2605);
        sel = 2'd1;
        step();
        check("man_ch1", 32'(s_mux), 32'h1046);
        check("man_upd", 32'(upd), 32'h1);
        step();

        // blanking and out-of-range select
        sel = 2'd2;
        step();
        check("blank_ff40", 32'(s_mux), 32'hFF40);
        sel = 2'd3;
        step();
        check("oor_ch", 32'(ch_act), 32'h2);
        check("oor_s_mux", 32'(s_mux), 32'hFF40);
        check("oor_upd", 32'(upd), 32'h0);

        // scan with wrap
        sel = 2'd0;
        step();
        mode = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            wait_adv(n);
            check("scan_dwell", 32'(n), 32'(DWELL));
            check("scan_ch", 32'(ch_act), 32'(k % N_CH));
        end

        // hold mid-dwell
        for (int i = 0; i < 10 && m_cnt != 2; i++) step();
        check("hold_cnt_reached", 32'(m_cnt), 32'd2);
        held = s_mux;
        hold = 1'b1;
        for (int c = 0; c < N_CH; c++) ch_data[c] = 16'h9999;
        repeat (10) step();
        check("hold_s_mux", 32'(s_mux), 32'(held));
        hold = 1'b0;
        wait_adv(n);
        check("hold_resume", 32'(n), 32'd2);

        // mode change colliding with dwell expiry
        for (int c = 0; c < N_CH; c++) ch_data[c] = rand_word();
        for (int i = 0; i < 10 && m_cnt != DWELL - 1; i++) step();
        check("coll_cnt_reached", 32'(m_cnt), 32'(DWELL - 1));
        prev = int'(ch_act);
        tgt  = (prev + 2) % N_CH;
        sel  = SEL_W'(tgt);
        mode = 1'b0;
        step();
        check("coll_follow_sel", 32'(ch_act), 32'(tgt));

        // async reset mid-scan
        mode = 1'b1;
        repeat (6) step();
        async_reset();
        repeat (3) step();
        check("post_rst_ch", 32'(ch_act), 32'h0);
        wait_adv(n);
        check("post_rst_adv", 32'(ch_act), 32'h1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom % 20 == 0) mode = ~mode;
            if ($urandom % 10 == 0) hold = ~hold;
            if ($urandom % 4 == 0)  sel  = SEL_W'($urandom % 4);
            if ($urandom % 3 == 0)  ch_data[$urandom % N_CH] = rand_word();
            if ($urandom % 150 == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
